// File: rtl/escrita_framebuffer.sv
// Framebuffer writer: clears the VGA framebuffer, then writes the scaler's raster
// stream into it, centred and clipped. Define MOLDURA_EN to draw a 1-pixel 8'hFF ring around the image.
module escrita_framebuffer #(
  parameter int          FB_LARG   = 320,
  parameter int          FB_ALT    = 240,
  parameter logic [7:0]  COR_FUNDO = 8'h00,
  parameter int          ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       img_larg,
  input  logic [11:0]       img_alt,
  input  logic [7:0]        pixel_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              busy,
  output logic              done
);

  localparam int                FB_SIZE   = FB_LARG * FB_ALT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
  localparam logic [11:0]       FB_L12    = 12'(FB_LARG);
  localparam logic [11:0]       FB_A12    = 12'(FB_ALT);
  localparam logic [12:0]       FB_L13    = 13'(FB_LARG);
  localparam logic [12:0]       FB_A13    = 13'(FB_ALT);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RECV, S_FIN} state_t;

  state_t            r_state;
  logic [11:0]       r_larg, r_alt, r_off_x, r_off_y, r_col, r_row;
  logic [ADDR_W-1:0] r_clr_addr;

  logic [11:0]       w_off_x_new, w_off_y_new;
  logic [12:0]       w_px, w_py;
  logic              w_clip, w_last_col, w_last_row, w_empty;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [7:0]        w_clr_data;

  // Oversized images pin to the left/top edge instead of wrapping the subtraction.
  assign w_off_x_new = (img_larg > FB_L12) ? 12'd0 : ((FB_L12 - img_larg) >> 1);
  assign w_off_y_new = (img_alt  > FB_A12) ? 12'd0 : ((FB_A12 - img_alt)  >> 1);

  assign w_px       = {1'b0, r_off_x} + {1'b0, r_col};
  assign w_py       = {1'b0, r_off_y} + {1'b0, r_row};
  assign w_clip     = (w_px >= FB_L13) || (w_py >= FB_A13);
  assign w_pix_addr = ADDR_W'(w_py) * ADDR_W'(FB_LARG) + ADDR_W'(w_px);
  assign w_last_col = (r_col == r_larg - 12'd1);
  assign w_last_row = (r_row == r_alt - 12'd1);
  assign w_empty    = (r_larg == 12'd0) || (r_alt == 12'd0);

  assign in_ready   = (r_state == S_RECV);

`ifdef MOLDURA_EN
  logic [12:0] r_cx, r_cy;
  logic [13:0] w_x1, w_y1, w_xl, w_xr, w_yt, w_yb;
  logic        w_in_x, w_in_y, w_ring;

  // Coordinates are shifted by +1 so the ring column/row at -1 stays unsigned.
  assign w_x1   = 14'(r_cx) + 14'd1;
  assign w_y1   = 14'(r_cy) + 14'd1;
  assign w_xl   = 14'(r_off_x);
  assign w_yt   = 14'(r_off_y);
  assign w_xr   = 14'(r_off_x) + 14'(r_larg) + 14'd1;
  assign w_yb   = 14'(r_off_y) + 14'(r_alt) + 14'd1;
  assign w_in_x = (w_x1 >= w_xl) && (w_x1 <= w_xr);
  assign w_in_y = (w_y1 >= w_yt) && (w_y1 <= w_yb);
  assign w_ring = w_in_x && w_in_y &&
                  ((w_x1 == w_xl) || (w_x1 == w_xr) || (w_y1 == w_yt) || (w_y1 == w_yb));
  assign w_clr_data = w_ring ? 8'hFF : COR_FUNDO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_state == S_IDLE) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_state == S_CLEAR) begin
      if (r_cx == 13'(FB_LARG - 1)) begin
        r_cx <= '0;
        r_cy <= r_cy + 13'd1;
      end else begin
        r_cx <= r_cx + 13'd1;
      end
    end
  end
`else
  assign w_clr_data = COR_FUNDO;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_larg     <= '0;
      r_alt      <= '0;
      r_off_x    <= '0;
      r_off_y    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_clr_addr <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: defaults first make fb_we and done single-cycle pulses unless a state re-asserts them.
      fb_we <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_larg     <= img_larg;
            r_alt      <= img_alt;
            r_off_x    <= w_off_x_new;
            r_off_y    <= w_off_y_new;
            r_col      <= '0;
            r_row      <= '0;
            r_clr_addr <= '0;
            busy       <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          fb_we   <= 1'b1;
          fb_addr <= r_clr_addr;
          fb_data <= w_clr_data;
          if (r_clr_addr == LAST_ADDR) begin
            r_state <= w_empty ? S_FIN : S_RECV;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
          end
        end
        S_RECV: begin
          if (in_valid) begin
            fb_we   <= !w_clip;
            fb_addr <= w_pix_addr;
            fb_data <= pixel_in;
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) r_state <= S_FIN;
              else            r_row   <= r_row + 12'd1;
            end else begin
              r_col <= r_col + 12'd1;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escrita_framebuffer.sv
// Directed bench for escrita_framebuffer on a reduced 32x24 framebuffer with a
// non-zero background colour; all expected addresses and data are hand-derived.
module tb_escrita_framebuffer;

  localparam int         FB_L = 32;
  localparam int         FB_A = 24;
  localparam int         N    = FB_L * FB_A;
  localparam int         AW   = 19;
  localparam logic [7:0] BG   = 8'h3C;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, fb_we, busy, done;
  logic [11:0]   img_larg, img_alt;
  logic [7:0]    pixel_in, fb_data;
  logic [AW-1:0] fb_addr;

  always #5 clk = ~clk;

  escrita_framebuffer #(.FB_LARG(FB_L), .FB_ALT(FB_A), .COR_FUNDO(BG), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .img_larg(img_larg), .img_alt(img_alt),
    .pixel_in(pixel_in), .in_valid(in_valid), .in_ready(in_ready), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done)
  );

  int total_cnt, bad_cnt;
  int clr_cnt, clr_bad, dat_cnt, dat_bad, done_cnt, beats, last_acc, done_at;
  int first_addr, first_data, last_addr, last_data;
  logic [7:0] clr_mem [N];
  logic [7:0] dat_mem [N];
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int b);
    return 8'(b * 7 + 165);
  endfunction

  // Observes one cycle of the write port; pend says a data write is due now.
  task automatic sample(input bit pend);
    int a;
    a = int'(fb_addr);
    if (fb_we) begin
      if (clr_cnt < N) begin
        if (a != clr_cnt) clr_bad++;
`ifndef MOLDURA_EN
        if (fb_data != BG) clr_bad++;
`endif
        if (a < N) clr_mem[a] = fb_data;
        clr_cnt++;
      end else begin
        if (!pend || exp_q.size() == 0) dat_bad++;
        else if (exp_q.pop_front() != ((a << 8) | int'(fb_data))) dat_bad++;
        if (dat_cnt == 0) begin
          first_addr = a;
          first_data = int'(fb_data);
        end
        last_addr = a;
        last_data = int'(fb_data);
        if (a < N) dat_mem[a] = fb_data;
        dat_cnt++;
      end
    end else if (pend) begin
      dat_bad++;
    end
    if (done) done_cnt++;
  endtask

  task automatic run_frame(input int larg, input int alt, input bit tog,
                           input int rs_a, input int rs_b, input int rst_beat);
    int ox, oy, total, budget, cyc, col, row;
    bit acc, pend;
    clr_cnt = 0; clr_bad = 0; dat_cnt = 0; dat_bad = 0; done_cnt = 0; beats = 0;
    first_addr = -1; first_data = -1; last_addr = -1; last_data = -1;
    last_acc = -1; done_at = -1;
    exp_q.delete();
    ox = (larg > FB_L) ? 0 : (FB_L - larg) / 2;
    oy = (alt > FB_A) ? 0 : (FB_A - alt) / 2;
    total  = larg * alt;
    budget = N + 2 * total + 40;
    @(negedge clk);
    img_larg = 12'(larg);
    img_alt  = 12'(alt);
    start    = 1'b1;
    cyc  = 0;
    pend = 1'b0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      sample(pend);
      if (done_cnt != 0) begin
        done_at = cyc;
        break;
      end
      start = (cyc == rs_a) || (cyc == rs_b);
      if (start) begin
        img_larg = 12'd1;
        img_alt  = 12'd1;
      end
      in_valid = (beats < total) && (!tog || cyc[0]);
      pixel_in = pix(beats);
      acc = in_valid && in_ready;
      if (rst_beat >= 0 && beats == rst_beat) begin
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ctl", int'({fb_we, busy, done, in_ready}), 0);
        check("rst_mid_addr", int'(fb_addr), 0);
        check("rst_mid_data", int'(fb_data), 0);
        in_valid = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      pend = 1'b0;
      if (acc) begin
        col = beats % larg;
        row = beats / larg;
        if (ox + col < FB_L && oy + row < FB_A) begin
          pend = 1'b1;
          exp_q.push_back((((oy + row) * FB_L + ox + col) << 8) | int'(pixel_in));
        end
        beats++;
        last_acc = cyc;
      end
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sample(1'b0);
    end
  endtask

  task automatic frame_checks(input string tag, input int exp_beats, input int exp_dat,
                              input int exp_first, input int exp_fdata,
                              input int exp_last, input int exp_ldata);
    check({tag, "_clr_cnt"}, clr_cnt, N);
    check({tag, "_clr_bad"}, clr_bad, 0);
    check({tag, "_beats"}, beats, exp_beats);
    check({tag, "_dat_cnt"}, dat_cnt, exp_dat);
    check({tag, "_dat_bad"}, dat_bad, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_end"}, int'(busy), 0);
    if (exp_dat > 0) begin
      check({tag, "_first_addr"}, first_addr, exp_first);
      check({tag, "_first_data"}, first_data, exp_fdata);
      check({tag, "_last_addr"}, last_addr, exp_last);
      check({tag, "_last_data"}, last_data, exp_ldata);
      check({tag, "_done_lat"}, done_at - last_acc, 2);
    end
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; pixel_in = '0;
    img_larg = '0; img_alt = '0;
    #12;
    check("reset_ctl", int'({fb_we, busy, done, in_ready}), 0);
    check("reset_addr", int'(fb_addr), 0);
    check("reset_data", int'(fb_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // 16x12 centred at (8,6): first 6*32+8, last 17*32+23
    run_frame(16, 12, 1'b0, -1, -1, -1);
    frame_checks("f16x12", 192, 192, 200, 8'hA5, 567, 8'hDE);
    check("f16x12_mem200", int'(dat_mem[200]), 8'hA5);
    check("clr_addr0", int'(clr_mem[0]), int'(BG));
    check("clr_inside", int'(clr_mem[200]), int'(BG));
`ifdef MOLDURA_EN
    check("ring_tl", int'(clr_mem[167]), 8'hFF);
    check("ring_br", int'(clr_mem[600]), 8'hFF);
    check("ring_top", int'(clr_mem[170]), 8'hFF);
    check("ring_off", int'(clr_mem[166]), int'(BG));
`else
    check("noring_tl", int'(clr_mem[167]), int'(BG));
    check("noring_br", int'(clr_mem[600]), int'(BG));
`endif

    // 8x6 at (12,9), valid every other cycle: first 300, last 14*32+19
    run_frame(8, 6, 1'b1, -1, -1, -1);
    frame_checks("f8x6_tog", 48, 48, 300, 8'hA5, 467, 8'hEE);

    // 40x2 wider than framebuffer: off (0,11), cols 32..39 consumed but clipped
    run_frame(40, 2, 1'b0, -1, -1, -1);
    frame_checks("f40x2", 80, 64, 352, 8'hA5, 415, 8'h96);

    // start re-pulsed in CLEAR and in RECV with a different size: ignored
    run_frame(16, 12, 1'b0, 100, N + 30, -1);
    frame_checks("f_restart", 192, 192, 200, 8'hA5, 567, 8'hDE);

    // zero-width image: clear only, then done
    run_frame(0, 5, 1'b0, -1, -1, -1);
    frame_checks("f_empty", 0, 0, 0, 0, 0, 0);

    // async reset mid-RECV, then a full frame restarting the clear at address 0
    run_frame(16, 12, 1'b0, -1, -1, 20);
    check("rst_after_ready", int'(in_ready), 0);
    run_frame(16, 12, 1'b0, -1, -1, -1);
    frame_checks("f_after_rst", 192, 192, 200, 8'hA5, 567, 8'hDE);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
